// File: rtl/y_drive_sequencer.sv
// Core-memory Y-drive sequencer: latches a one-hot Y group select, then runs
// read drive, a dead gap and write drive, with a sense strobe and completion pulse.
module y_drive_sequencer #(
    parameter int READ_CYC  = 4,
    parameter int GAP_CYC   = 2,
    parameter int WRITE_CYC = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       AY00N,
    input  logic       AY10N,
    input  logic       AY20N,
    input  logic       AY30N,
    input  logic       AY40N,
    input  logic       AY50N,
    input  logic       AY60N,
    input  logic       AY70N,
    input  logic       STRT,
    output logic [7:0] YRD,
    output logic [7:0] YWR,
    output logic       SENS,
    output logic       BUSY,
    output logic       DONE,
    output logic       ADRERR,
    output logic       ORUN
);

    localparam int MAX_RG = (READ_CYC > GAP_CYC) ? READ_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_RG > WRITE_CYC) ? MAX_RG : WRITE_CYC;
    localparam int CW = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] READ_LD  = CW'(READ_CYC - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] WRITE_LD = CW'(WRITE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        READ  = 3'd2,
        GAP   = 3'd3,
        WRITE = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    ysel, ysel_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          adrerr_nxt, orun_nxt;
    logic [7:0]    yrd_nxt, ywr_nxt;
    logic          sens_nxt, busy_nxt, done_nxt;

    logic [7:0] ay_sel;
    logic       ay_onehot;

    assign ay_sel    = ~{AY70N, AY60N, AY50N, AY40N, AY30N, AY20N, AY10N, AY00N};
    assign ay_onehot = (ay_sel != 8'd0) && ((ay_sel & (ay_sel - 8'd1)) == 8'd0);

    always_comb begin
        state_nxt  = state;
        ysel_nxt   = ysel;
        cnt_nxt    = cnt;
        adrerr_nxt = ADRERR;
        orun_nxt   = ORUN;

        // A start seen in IDLE is accepted and clears the sticky flags;
        // anywhere else it is dropped and flagged as an overrun.
        if (STRT) begin
            if (state == IDLE) begin
                adrerr_nxt = 1'b0;
                orun_nxt   = 1'b0;
            end else begin
                orun_nxt   = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (STRT) state_nxt = LATCH;
            end
            LATCH: begin
                ysel_nxt = ay_sel;
                if (ay_onehot) begin
                    state_nxt = READ;
                    cnt_nxt   = READ_LD;
                end else begin
                    state_nxt  = FIN;
                    adrerr_nxt = 1'b1;
                end
            end
            READ: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = WRITE;
                    cnt_nxt   = WRITE_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WRITE: begin
                if (cnt == '0) state_nxt = FIN;
                else           cnt_nxt   = cnt - 1'b1;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next-state values so the registered copies
    // line up cycle-for-cycle with the state they describe.
    always_comb begin
        yrd_nxt  = (state_nxt == READ)  ? ysel_nxt : 8'd0;
        ywr_nxt  = (state_nxt == WRITE) ? ysel_nxt : 8'd0;
        sens_nxt = (state_nxt == READ) && (cnt_nxt == '0);
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == FIN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            ysel   <= 8'd0;
            cnt    <= '0;
            YRD    <= 8'd0;
            YWR    <= 8'd0;
            SENS   <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            ADRERR <= 1'b0;
            ORUN   <= 1'b0;
        end else begin
            state  <= state_nxt;
            ysel   <= ysel_nxt;
            cnt    <= cnt_nxt;
            YRD    <= yrd_nxt;
            YWR    <= ywr_nxt;
            SENS   <= sens_nxt;
            BUSY   <= busy_nxt;
            DONE   <= done_nxt;
            ADRERR <= adrerr_nxt;
            ORUN   <= orun_nxt;
        end
    end

endmodule
